// File: rtl/seven_seg_capture_if.sv
// Pin-side bundle for seven_seg_capture.
//   seg[6:0] : segment pins, seg[0]=a .. seg[6]=g (asynchronous to the capture clock)
//   ca       : digit select pin, 0 = digit 0, 1 = digit 1
//   digit0/1 : last legal nibble captured per digit
//   valid0/1 : digit currently shows a legal glyph
//   err      : one-cycle pulse on an accepted pattern that is neither hex glyph nor blank
//   frame    : one-cycle pulse when a legal digit-1 capture follows a legal digit-0 capture
// master = the side driving the pins and watching results; slave = the capture block.
interface seven_seg_capture_if;
  logic [6:0] seg;
  logic       ca;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       valid0;
  logic       valid1;
  logic       err;
  logic       frame;

  modport master (
    output seg, ca,
    input  digit0, digit1, valid0, valid1, err, frame
  );

  modport slave (
    input  seg, ca,
    output digit0, digit1, valid0, valid1, err, frame
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of a two-digit multiplexed seven-segment bus. Synchronises {ca,seg},
// waits for each digit phase to settle, decodes the glyph back to a hex nibble and
// holds it per digit; pulses frame once both digits of a refresh cycle are captured.
// Ports:
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : seven_seg_capture_if.slave (seg/ca in; digit0/1, valid0/1, err, frame out)
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic            CLK,
  input logic            RST,
  seven_seg_capture_if.slave bus
);

  localparam int unsigned     CntW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  localparam logic [0:0] StWait0 = 1'b0;
  localparam logic [0:0] StWait1 = 1'b1;

  // Returns {legal, nibble} for a pattern read as {g,f,e,d,c,b,a}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [7:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accepted_q, accepted_d;
  logic [3:0]      digit0_q, digit0_d, digit1_q, digit1_d;
  logic            valid0_q, valid0_d, valid1_q, valid1_d;
  logic            err_q, err_d, frame_q, frame_d;
  logic [0:0]      state_q, state_d;

  logic       match, accept, legal, blank, phase;
  logic [6:0] pat;
  logic [3:0] nib;

  always_comb begin
    sync1_d = {bus.ca, bus.seg};
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    match = (sync2_q == prev_q);
    cnt_d = '0;
    if (match) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end
    // One accept per stable period; the saturated count plus the flag suppress repeats.
    accept     = match && (cnt_d == CntMax) && !accepted_q;
    accepted_d = match && (accepted_q || accept);

    pat          = SEG_ACTIVE_LOW ? ~sync2_q[6:0] : sync2_q[6:0];
    {legal, nib} = decode(pat);
    blank        = (pat == 7'h00);
    phase        = sync2_q[7];

    digit0_d = digit0_q;
    digit1_d = digit1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    err_d    = 1'b0;
    frame_d  = 1'b0;
    state_d  = state_q;

    if (accept) begin
      if (legal) begin
        if (phase) begin
          digit1_d = nib;
          valid1_d = 1'b1;
        end else begin
          digit0_d = nib;
          valid0_d = 1'b1;
        end
      end else begin
        if (phase) valid1_d = 1'b0;
        else       valid0_d = 1'b0;
        err_d = !blank;
      end

      if (state_q == StWait0) begin
        if (legal && !phase) state_d = StWait1;
      end else begin
        if (legal && phase) begin
          frame_d = 1'b1;
          state_d = StWait0;
        end else if (!legal) begin
          state_d = StWait0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      // Set so the reset contents of the synchroniser are never accepted.
      accepted_q <= 1'b1;
      digit0_q   <= '0;
      digit1_q   <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
      state_q    <= StWait0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      accepted_q <= accepted_d;
      digit0_q   <= digit0_d;
      digit1_q   <= digit1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
      state_q    <= state_d;
    end
  end

  assign bus.digit0 = digit0_q;
  assign bus.digit1 = digit1_q;
  assign bus.valid0 = valid0_q;
  assign bus.valid1 = valid1_q;
  assign bus.err    = err_q;
  assign bus.frame  = frame_q;

endmodule
